mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ws_allowin, input, 1, WB stage can accept.
REQ-004 SHALL have port ms_allowin, output, 1, MEM stage can accept from EXE.
REQ-005 SHALL have port es_to_ms_valid, input, 1, EXE payload valid.
REQ-006 SHALL have port es_to_ms_bus, input, 110, {csr_data[33:0], ld_op[4:0]={ld_b,ld_bu,ld_h,ld_hu,ld_w}, mem_req, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}.
REQ-007 SHALL have port es_req_inflight, input, 1, EXE has issued a data request whose data_ok is not yet returned.
REQ-008 SHALL have port data_sram_data_ok, input, 1, data response strobe.
REQ-009 SHALL have port data_sram_rdata, input, 32, read data, valid with data_ok.
REQ-010 SHALL have port wb_ex, input, 1, WB exception flush.
REQ-011 SHALL have port ms_to_ws_valid, output, 1, payload valid to WB.
REQ-012 SHALL have port ms_to_ws_bus, output, 104, {csr_data[33:0], gr_we, dest[4:0], final_result[31:0], pc[31:0]}.
REQ-013 SHALL have port ms_fwd_bus, output, 40, {ms_valid, gr_we&ms_valid, dest[4:0], final_result[31:0], load_pending}.
REQ-014 SHALL have port ms_ex, output, 1, ms_valid & (csr_data[30] ertn | csr_data[29] syscall); EXE suppresses stores.

Function
REQ-015 SHALL latch es_to_ms_bus into bus_r when es_to_ms_valid && ms_allowin; bus_r otherwise holds.
REQ-016 SHALL update ms_valid: wb_ex -> 0; else if ms_allowin -> es_to_ms_valid; else hold.
REQ-017 SHALL drive ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
REQ-018 SHALL drive ms_ready_go = !mem_req | data_ok_accepted | (state==BUF).
REQ-019 SHALL drive ms_to_ws_valid = ms_valid & ms_ready_go & !wb_ex.
REQ-020 SHALL run data FSM {IDLE, WAIT, BUF}: entry of valid mem_req instruction -> WAIT; WAIT + accepted data_ok + ws_allowin -> IDLE (or WAIT if a new mem_req enters same cycle); WAIT + accepted data_ok + !ws_allowin -> BUF, capture rdata in rdata_buf; BUF + hand-off -> IDLE/WAIT per next instruction.
REQ-021 SHALL keep 2-bit discard_cnt (0..2); data_ok with discard_cnt!=0 is dropped and decrements it; data_ok is accepted only when discard_cnt==0.
REQ-022 On wb_ex SHALL add (ms_valid & state==WAIT) + es_req_inflight to discard_cnt, force FSM IDLE, clear rdata_buf; simultaneous data_ok that cycle consumes one count first.
REQ-023 SHALL select load data = state==BUF ? rdata_buf : data_sram_rdata.
REQ-024 SHALL extract: byte = data >> {alu_result[1:0],3'b0}; half = alu_result[1] ? data[31:16] : data[15:0]; ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w full word.
REQ-025 SHALL set final_result = (mem_req & |ld_op) ? load_result : alu_result; stores pass alu_result and still wait for data_ok.
REQ-026 SHALL set load_pending = ms_valid & |ld_op & !ms_ready_go.
REQ-027 SHALL pass csr_data, gr_we, dest, pc from bus_r unchanged.

Reset
REQ-028 SHALL on resetn low asynchronously clear ms_valid, FSM to IDLE, discard_cnt 0, rdata_buf 0; bus_r unreset.
REQ-029 SHALL after reset drive ms_to_ws_valid 0, ms_allowin 1, ms_ex 0, ms_fwd_bus[39] 0.
REQ-030 SHALL recover from resetn mid-WAIT with no pending-response memory.

Verification
REQ-031 ld_w, addr 0x100, data_ok next cycle rdata 0x11223344, ws_allowin 1 -> ms_to_ws_valid 1 that cycle, final_result 0x11223344.
REQ-032 ld_b addr low 2'b11, rdata 0x80AABBCC -> 0xFFFFFF80; ld_bu -> 0x00000080; ld_hu addr 2'b10 -> 0x000080AA.
REQ-033 data_ok with ws_allowin 0 for 3 cycles -> FSM BUF, ms_allowin 0, result held; ws_allowin 1 -> single hand-off, IDLE.
REQ-034 wb_ex during WAIT with es_req_inflight 1 -> discard_cnt 2; next two data_ok dropped, ms_to_ws_valid stays 0, third accepted.
REQ-035 ALU op (mem_req 0) back-to-back with ws_allowin 1 -> one instruction per cycle, final_result = alu_result, load_pending 0.
REQ-036 syscall in MEM -> ms_ex 1; wb_ex next -> ms_valid 0 next edge.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the five-stage pipeline: waits for the data SRAM response, buffers it
// while WB stalls, extracts the load value, and discards responses orphaned by a flush.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [109:0] es_to_ms_bus,
    input  logic         es_req_inflight,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         wb_ex,
    output logic         ms_to_ws_valid,
    output logic [103:0] ms_to_ws_bus,
    output logic [39:0]  ms_fwd_bus,
    output logic         ms_ex
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BUF  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          ms_valid;
    logic [109:0]  bus_r;
    logic [1:0]    discard_cnt;
    logic [1:0]    discard_next;
    logic [31:0]   rdata_buf;

    logic [33:0]   csr_data;
    logic          ld_b;
    logic          ld_bu;
    logic          ld_h;
    logic          ld_hu;
    logic          ld_w;
    logic          mem_req;
    logic          gr_we;
    logic [4:0]    dest;
    logic [31:0]   alu_result;
    logic [31:0]   pc;
    logic          is_load;

    logic          es_mem_req;
    logic          data_ok_accepted;
    logic          ms_ready_go;
    logic          entering;
    logic          next_is_mem;

    logic [2:0]    discard_sum;
    logic          discard_drop;
    logic [2:0]    discard_left;

    logic [31:0]   load_data;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_result;
    logic [31:0]   final_result;
    logic          load_pending;

    assign csr_data   = bus_r[109:76];
    assign ld_b       = bus_r[75];
    assign ld_bu      = bus_r[74];
    assign ld_h       = bus_r[73];
    assign ld_hu      = bus_r[72];
    assign ld_w       = bus_r[71];
    assign mem_req    = bus_r[70];
    assign gr_we      = bus_r[69];
    assign dest       = bus_r[68:64];
    assign alu_result = bus_r[63:32];
    assign pc         = bus_r[31:0];
    assign is_load    = ld_b | ld_bu | ld_h | ld_hu | ld_w;

    assign es_mem_req = es_to_ms_bus[70];

    // Only a response arriving while waiting with nothing left to discard belongs to us.
    assign data_ok_accepted = data_sram_data_ok & (discard_cnt == 2'd0) & (state == S_WAIT);
    assign ms_ready_go      = !mem_req | data_ok_accepted | (state == S_BUF);
    assign ms_allowin       = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid   = ms_valid & ms_ready_go & !wb_ex;
    assign entering         = es_to_ms_valid & ms_allowin;
    assign next_is_mem      = entering & es_mem_req;

    always_comb begin
        state_next = state;
        if (wb_ex) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (next_is_mem) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (data_ok_accepted) begin
                        if (ws_allowin) state_next = next_is_mem ? S_WAIT : S_IDLE;
                        else            state_next = S_BUF;
                    end
                end
                S_BUF: begin
                    if (ws_allowin) state_next = next_is_mem ? S_WAIT : S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // A flush orphans the waiting response and EXE's in-flight one; a coincident data_ok pays one off.
    always_comb begin
        discard_sum  = {1'b0, discard_cnt}
                     + {2'b00, wb_ex & ms_valid & (state == S_WAIT)}
                     + {2'b00, wb_ex & es_req_inflight};
        discard_drop = data_sram_data_ok & (discard_sum != 3'd0);
        discard_left = discard_sum - {2'b00, discard_drop};
        discard_next = (discard_left > 3'd3) ? 2'd3 : discard_left[1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            ms_valid    <= 1'b0;
            discard_cnt <= 2'd0;
            rdata_buf   <= 32'd0;
        end else begin
            state       <= state_next;
            discard_cnt <= discard_next;
            if (wb_ex)           ms_valid <= 1'b0;
            else if (ms_allowin) ms_valid <= es_to_ms_valid;
            if (wb_ex)
                rdata_buf <= 32'd0;
            else if (data_ok_accepted && !ws_allowin)
                rdata_buf <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) bus_r <= es_to_ms_bus;
    end

    assign load_data = (state == S_BUF) ? rdata_buf : data_sram_rdata;
    assign load_half = alu_result[1] ? load_data[31:16] : load_data[15:0];

    always_comb begin
        load_byte = load_data[7:0];
        unique case (alu_result[1:0])
            2'b00:   load_byte = load_data[7:0];
            2'b01:   load_byte = load_data[15:8];
            2'b10:   load_byte = load_data[23:16];
            2'b11:   load_byte = load_data[31:24];
            default: load_byte = load_data[7:0];
        endcase
    end

    always_comb begin
        load_result = load_data;
        if (ld_b)       load_result = {{24{load_byte[7]}}, load_byte};
        else if (ld_bu) load_result = {24'd0, load_byte};
        else if (ld_h)  load_result = {{16{load_half[15]}}, load_half};
        else if (ld_hu) load_result = {16'd0, load_half};
        else            load_result = load_data;
    end

    assign final_result = (mem_req & is_load) ? load_result : alu_result;
    assign load_pending = ms_valid & is_load & !ms_ready_go;

    assign ms_to_ws_bus = {csr_data, gr_we, dest, final_result, pc};
    assign ms_fwd_bus   = {ms_valid, gr_we & ms_valid, dest, final_result, load_pending};
    assign ms_ex        = ms_valid & (csr_data[30] | csr_data[29]);

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a behavioural load/pipeline model.
module tb_mem_stage;

    logic         clk;
    logic         resetn;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [109:0] es_to_ms_bus;
    logic         es_req_inflight;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_ex;
    logic         ms_to_ws_valid;
    logic [103:0] ms_to_ws_bus;
    logic [39:0]  ms_fwd_bus;
    logic         ms_ex;

    int checks = 0;
    int passed = 0;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00001;

    typedef struct {
        logic [33:0] csr;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] pc;
    } exp_t;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .es_req_inflight   (es_req_inflight),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_fwd_bus        (ms_fwd_bus),
        .ms_ex             (ms_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [109:0] make_bus(input logic [33:0] csr, input logic [4:0] ld_op,
                                              input logic mem_req, input logic gr_we,
                                              input logic [4:0] dest, input logic [31:0] alu,
                                              input logic [31:0] pc);
        return {csr, ld_op, mem_req, gr_we, dest, alu, pc};
    endfunction

    // Reference load value computed arithmetically from the address and the raw word.
    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] addr,
                                             input logic [31:0] data);
        longint d;
        longint sh;
        longint byte_v;
        longint half_v;
        d      = longint'(data);
        sh     = longint'(addr % 4);
        byte_v = (d / (256 ** sh)) % 256;
        half_v = (sh >= 2) ? (d / 65536) : (d % 65536);
        case (op)
            LD_W:    return data;
            LD_B:    return (byte_v >= 128) ? 32'(byte_v - 256) : 32'(byte_v);
            LD_BU:   return 32'(byte_v);
            LD_H:    return (half_v >= 32768) ? 32'(half_v - 65536) : 32'(half_v);
            LD_HU:   return 32'(half_v);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Issues one load, returns data the following cycle, reports what WB would see.
    task automatic do_load(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rdata,
                           output logic vld, output logic [31:0] res);
        @(negedge clk);
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(34'd0, op, 1'b1, 1'b1, 5'd7, addr, 32'h1C00_0000);
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        #1;
        vld = ms_to_ws_valid;
        res = ms_to_ws_bus[63:32];
        @(posedge clk);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", ms_to_ws_valid); else passed++;
        checks++; if (ms_allowin !== 1'b1) $display("[TB] FAIL reset_allowin: got %b expected 1", ms_allowin); else passed++;
        checks++; if (ms_ex !== 1'b0) $display("[TB] FAIL reset_ms_ex: got %b expected 0", ms_ex); else passed++;
        checks++; if (ms_fwd_bus[39] !== 1'b0) $display("[TB] FAIL reset_fwd_valid: got %b expected 0", ms_fwd_bus[39]); else passed++;
        resetn = 1'b1;
    endtask

    task automatic test_ld_w();
        logic vld;
        logic [31:0] res;
        do_load(LD_W, 32'h0000_0100, 32'h1122_3344, vld, res);
        checks++; if (vld !== 1'b1) $display("[TB] FAIL ld_w_valid: got %b expected 1", vld); else passed++;
        checks++; if (res !== 32'h1122_3344) $display("[TB] FAIL ld_w_result: got %h expected 11223344", res); else passed++;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) $display("[TB] FAIL ld_w_drain: got %b expected 0", ms_to_ws_valid); else passed++;
    endtask

    task automatic test_load_extract();
        logic vld;
        logic [31:0] res;
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        do_load(LD_B, 32'h0000_0203, 32'h80AA_BBCC, vld, res);
        checks++; if (res !== 32'hFFFF_FF80) $display("[TB] FAIL ld_b_fixed: got %h expected ffffff80", res); else passed++;
        do_load(LD_BU, 32'h0000_0203, 32'h80AA_BBCC, vld, res);
        checks++; if (res !== 32'h0000_0080) $display("[TB] FAIL ld_bu_fixed: got %h expected 00000080", res); else passed++;
        do_load(LD_HU, 32'h0000_0202, 32'h80AA_BBCC, vld, res);
        checks++; if (res !== 32'h0000_80AA) $display("[TB] FAIL ld_hu_fixed: got %h expected 000080aa", res); else passed++;
        for (int i = 0; i < 30; i++) begin
            op    = 5'b00001 << $urandom_range(0, 4);
            addr  = $urandom;
            rdata = $urandom;
            if (op == LD_W) addr[1:0] = 2'b00;
            if (op == LD_H || op == LD_HU) addr[0] = 1'b0;
            do_load(op, addr, rdata, vld, res);
            checks++; if (vld !== 1'b1) $display("[TB] FAIL load_rand_valid[%0d]: got %b expected 1", i, vld); else passed++;
            checks++;
            if (res !== ref_load(op, addr, rdata))
                $display("[TB] FAIL load_rand_result[%0d] op=%b addr=%h data=%h: got %h expected %h",
                         i, op, addr, rdata, res, ref_load(op, addr, rdata));
            else passed++;
        end
    endtask

    task automatic test_buf_stall();
        logic [31:0] addr;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] exp_v;
        addr = $urandom; addr[0] = 1'b0;
        r1 = $urandom;
        r2 = $urandom;
        exp_v = ref_load(LD_H, addr, r1);
        @(negedge clk);
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(34'd0, LD_H, 1'b1, 1'b1, 5'd9, addr, 32'h1C00_0040);
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = r1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1) $display("[TB] FAIL buf_first_valid: got %b expected 1", ms_to_ws_valid); else passed++;
        checks++; if (ms_allowin !== 1'b0) $display("[TB] FAIL buf_first_allowin: got %b expected 0", ms_allowin); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = ~r1;
            #1;
            checks++; if (ms_to_ws_valid !== 1'b1) $display("[TB] FAIL buf_hold_valid[%0d]: got %b expected 1", i, ms_to_ws_valid); else passed++;
            checks++; if (ms_allowin !== 1'b0) $display("[TB] FAIL buf_hold_allowin[%0d]: got %b expected 0", i, ms_allowin); else passed++;
            checks++; if (ms_to_ws_bus[63:32] !== exp_v) $display("[TB] FAIL buf_hold_result[%0d]: got %h expected %h", i, ms_to_ws_bus[63:32], exp_v); else passed++;
            checks++; if (ms_fwd_bus[0] !== 1'b0) $display("[TB] FAIL buf_hold_pending[%0d]: got %b expected 0", i, ms_fwd_bus[0]); else passed++;
        end
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        checks++; if (ms_allowin !== 1'b1) $display("[TB] FAIL buf_release_allowin: got %b expected 1", ms_allowin); else passed++;
        checks++; if (ms_to_ws_bus[63:32] !== exp_v) $display("[TB] FAIL buf_release_result: got %h expected %h", ms_to_ws_bus[63:32], exp_v); else passed++;
        @(negedge clk);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) $display("[TB] FAIL buf_single_handoff: got %b expected 0", ms_to_ws_valid); else passed++;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(34'd0, LD_W, 1'b1, 1'b1, 5'd10, 32'h0000_0300, 32'h1C00_0044);
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        checks++; if (ms_fwd_bus[0] !== 1'b1) $display("[TB] FAIL buf_next_pending: got %b expected 1", ms_fwd_bus[0]); else passed++;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = r2;
        #1;
        checks++; if (ms_to_ws_bus[63:32] !== r2) $display("[TB] FAIL buf_next_result: got %h expected %h", ms_to_ws_bus[63:32], r2); else passed++;
        @(posedge clk);
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_discard();
        logic [31:0] r;
        @(negedge clk);
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(34'd0, LD_W, 1'b1, 1'b1, 5'd4, 32'h0000_0400, 32'h1C00_0080);
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        wb_ex           = 1'b1;
        es_req_inflight = 1'b1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", ms_to_ws_valid); else passed++;
        @(negedge clk);
        wb_ex           = 1'b0;
        es_req_inflight = 1'b0;
        #1;
        checks++; if (ms_fwd_bus[39] !== 1'b0) $display("[TB] FAIL flush_ms_valid: got %b expected 0", ms_fwd_bus[39]); else passed++;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(34'd0, LD_W, 1'b1, 1'b1, 5'd5, 32'h0000_0500, 32'h1C00_0084);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            es_to_ms_valid    = 1'b0;
            r                 = $urandom;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = r;
            #1;
            if (k < 2) begin
                checks++; if (ms_to_ws_valid !== 1'b0) $display("[TB] FAIL discard_drop[%0d]: got %b expected 0", k, ms_to_ws_valid); else passed++;
                checks++; if (ms_fwd_bus[0] !== 1'b1) $display("[TB] FAIL discard_pending[%0d]: got %b expected 1", k, ms_fwd_bus[0]); else passed++;
            end else begin
                checks++; if (ms_to_ws_valid !== 1'b1) $display("[TB] FAIL discard_accept: got %b expected 1", ms_to_ws_valid); else passed++;
                checks++; if (ms_to_ws_bus[63:32] !== r) $display("[TB] FAIL discard_result: got %h expected %h", ms_to_ws_bus[63:32], r); else passed++;
            end
        end
        @(negedge clk);
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        exp_t n;
        ws_allowin = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (i < 20) begin
                n.csr   = {2'($urandom_range(0, 3)), 32'($urandom)};
                n.gr_we = 1'($urandom);
                n.dest  = 5'($urandom);
                n.alu   = $urandom;
                n.pc    = $urandom;
                q.push_back(n);
                es_to_ms_valid = 1'b1;
                es_to_ms_bus   = make_bus(n.csr, 5'd0, 1'b0, n.gr_we, n.dest, n.alu, n.pc);
            end else begin
                es_to_ms_valid = 1'b0;
            end
            #1;
            if (i > 0) begin
                e = q.pop_front();
                checks++; if (ms_to_ws_valid !== 1'b1) $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, ms_to_ws_valid); else passed++;
                checks++;
                if (ms_to_ws_bus !== {e.csr, e.gr_we, e.dest, e.alu, e.pc})
                    $display("[TB] FAIL b2b_bus[%0d]: got %h expected %h", i, ms_to_ws_bus, {e.csr, e.gr_we, e.dest, e.alu, e.pc});
                else passed++;
                checks++; if (ms_allowin !== 1'b1) $display("[TB] FAIL b2b_allowin[%0d]: got %b expected 1", i, ms_allowin); else passed++;
                checks++; if (ms_fwd_bus[0] !== 1'b0) $display("[TB] FAIL b2b_pending[%0d]: got %b expected 0", i, ms_fwd_bus[0]); else passed++;
                checks++; if (ms_fwd_bus[38] !== e.gr_we) $display("[TB] FAIL b2b_fwd_we[%0d]: got %b expected %b", i, ms_fwd_bus[38], e.gr_we); else passed++;
                checks++; if (ms_ex !== (e.csr[30] | e.csr[29])) $display("[TB] FAIL b2b_ms_ex[%0d]: got %b expected %b", i, ms_ex, e.csr[30] | e.csr[29]); else passed++;
            end
        end
        @(negedge clk);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) $display("[TB] FAIL b2b_drain: got %b expected 0", ms_to_ws_valid); else passed++;
    endtask

    task automatic test_syscall_flush();
        logic [33:0] csr;
        csr = 34'd0;
        csr[29] = 1'b1;
        @(negedge clk);
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(csr, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0000_0011, 32'h1C00_0100);
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        checks++; if (ms_ex !== 1'b1) $display("[TB] FAIL syscall_ms_ex: got %b expected 1", ms_ex); else passed++;
        wb_ex = 1'b1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) $display("[TB] FAIL syscall_flush_valid: got %b expected 0", ms_to_ws_valid); else passed++;
        @(negedge clk);
        wb_ex = 1'b0;
        #1;
        checks++; if (ms_fwd_bus[39] !== 1'b0) $display("[TB] FAIL syscall_ms_valid: got %b expected 0", ms_fwd_bus[39]); else passed++;
        checks++; if (ms_ex !== 1'b0) $display("[TB] FAIL syscall_ms_ex_clear: got %b expected 0", ms_ex); else passed++;
        checks++; if (ms_allowin !== 1'b1) $display("[TB] FAIL syscall_allowin: got %b expected 1", ms_allowin); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        logic vld;
        logic [31:0] res;
        logic [31:0] r;
        @(negedge clk);
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(34'd0, LD_W, 1'b1, 1'b1, 5'd6, 32'h0000_0600, 32'h1C00_0200);
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        wb_ex           = 1'b1;
        es_req_inflight = 1'b1;
        @(negedge clk);
        wb_ex           = 1'b0;
        es_req_inflight = 1'b0;
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = make_bus(34'd0, LD_W, 1'b1, 1'b1, 5'd6, 32'h0000_0604, 32'h1C00_0204);
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        resetn         = 1'b0;
        #1;
        checks++; if (ms_fwd_bus[39] !== 1'b0) $display("[TB] FAIL rst_wait_valid: got %b expected 0", ms_fwd_bus[39]); else passed++;
        checks++; if (ms_allowin !== 1'b1) $display("[TB] FAIL rst_wait_allowin: got %b expected 1", ms_allowin); else passed++;
        @(negedge clk);
        resetn = 1'b1;
        r = $urandom;
        do_load(LD_W, 32'h0000_0700, r, vld, res);
        checks++; if (vld !== 1'b1) $display("[TB] FAIL rst_recover_valid: got %b expected 1", vld); else passed++;
        checks++; if (res !== r) $display("[TB] FAIL rst_recover_result: got %h expected %h", res, r); else passed++;
    endtask

    initial begin
        resetn            = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        es_req_inflight   = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        wb_ex             = 1'b0;
        test_reset();
        test_ld_w();
        test_load_extract();
        test_buf_stall();
        test_discard();
        test_back_to_back();
        test_syscall_flush();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
